// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states and
// register-file geometry.
package alu_seq_pkg;

  localparam int REG_IDX_W = 2;
  localparam int REG_COUNT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry operand register file with two combinational read ports and a
// single write port shared between preload and ALU write-back.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_we_i,
  input  logic [REG_IDX_W-1:0] ld_addr_i,
  input  logic [WIDTH-1:0]     ld_data_i,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_addr_i,
  input  logic [WIDTH-1:0]     wb_data_i,
  input  logic [REG_IDX_W-1:0] ra_addr_i,
  input  logic [REG_IDX_W-1:0] rb_addr_i,
  output logic [WIDTH-1:0]     ra_data_o,
  output logic [WIDTH-1:0]     rb_data_o
);

  logic [WIDTH-1:0]     regs_q [REG_COUNT];
  logic                 we;
  logic [REG_IDX_W-1:0] waddr;
  logic [WIDTH-1:0]     wdata;

  // Preload only happens in IDLE and write-back only in EXEC, so the two
  // sources never collide; preload is given the mux priority anyway.
  assign we    = ld_we_i | wb_we_i;
  assign waddr = ld_we_i ? ld_addr_i : wb_addr_i;
  assign wdata = ld_we_i ? ld_data_i : wb_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle initiator for an external combinational ALU (IDLE/EXEC/RESP).
// Define ALU_SEQ_FLAGS_EN to register the ALU zero/carry flags at write-back.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_valid_i,
  output logic                 ld_ready_o,
  input  logic [REG_IDX_W-1:0] ld_addr_i,
  input  logic [WIDTH-1:0]     ld_data_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [2:0]           instr_op_i,
  input  logic [REG_IDX_W-1:0] instr_rd_i,
  input  logic [REG_IDX_W-1:0] instr_rs1_i,
  input  logic [REG_IDX_W-1:0] instr_rs2_i,
  output logic [WIDTH-1:0]     alu_a_o,
  output logic [WIDTH-1:0]     alu_b_o,
  output logic [2:0]           alu_sel_o,
  input  logic [WIDTH-1:0]     alu_result_i,
  input  logic                 alu_zero_i,
  input  logic                 alu_carry_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [WIDTH-1:0]     resp_data_o,
  output logic [REG_IDX_W-1:0] resp_rd_o,
  output logic                 flag_zero_o,
  output logic                 flag_carry_o
);

  state_e               state_q;
  logic [WIDTH-1:0]     alu_a_q, alu_b_q, resp_data_q;
  logic [2:0]           alu_sel_q;
  logic [REG_IDX_W-1:0] rd_q, resp_rd_q;
  logic [WIDTH-1:0]     rs1_data, rs2_data;
  logic                 ld_fire, instr_fire, wb_we;

  assign ld_ready_o    = (state_q == ST_IDLE);
  assign instr_ready_o = (state_q == ST_IDLE) && !ld_valid_i;
  assign ld_fire       = ld_valid_i && ld_ready_o;
  assign instr_fire    = instr_valid_i && instr_ready_o;
  assign wb_we         = (state_q == ST_EXEC);

  alu_seq_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ld_we_i   (ld_fire),
    .ld_addr_i (ld_addr_i),
    .ld_data_i (ld_data_i),
    .wb_we_i   (wb_we),
    .wb_addr_i (rd_q),
    .wb_data_i (alu_result_i),
    .ra_addr_i (instr_rs1_i),
    .rb_addr_i (instr_rs2_i),
    .ra_data_o (rs1_data),
    .rb_data_o (rs2_data)
  );

  // Operands are captured at accept, so a write-back to rs1/rs2 cannot
  // disturb the values the ALU sees during EXEC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
      resp_rd_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_fire) begin
            alu_a_q   <= rs1_data;
            alu_b_q   <= rs2_data;
            alu_sel_q <= instr_op_i;
            rd_q      <= instr_rd_i;
            state_q   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data_q <= alu_result_i;
          resp_rd_q   <= rd_q;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_zero_q, flag_carry_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      flag_zero_q  <= alu_zero_i;
      flag_carry_q <= alu_carry_i;
    end
  end

  assign flag_zero_o  = flag_zero_q;
  assign flag_carry_o = flag_carry_q;
`else
  logic unused_flags;
  assign unused_flags = alu_zero_i ^ alu_carry_i;
  assign flag_zero_o  = 1'b0;
  assign flag_carry_o = 1'b0;
`endif

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_rd_o    = resp_rd_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural ALU drives the DUT and an
// integer reference model predicts each response; a monitor pops and compares.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_valid = 1'b0, ld_ready;
  logic [1:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       instr_valid = 1'b0, instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_zero, alu_carry;
  logic       resp_valid, resp_ready = 1'b1;
  logic [7:0] resp_data;
  logic [1:0] resp_rd;
  logic       flag_zero, flag_carry;

  typedef struct {
    int data;
    int rd;
    int z;
    int c;
  } exp_t;

  exp_t sb_q[$];
  int   mreg[4];
  int   pass_cnt = 0, total_cnt = 0, resp_cnt = 0, issued = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_op_i(instr_op),
    .instr_rd_i(instr_rd), .instr_rs1_i(instr_rs1), .instr_rs2_i(instr_rs2),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero), .alu_carry_i(alu_carry),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_rd_o(resp_rd),
    .flag_zero_o(flag_zero), .flag_carry_o(flag_carry)
  );

  // External combinational ALU; carry is carry-out, borrow, or shifted-out bit.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = {7'd0, alu_a < alu_b};
      3'd6: {alu_carry, alu_result} = {alu_a, 1'b0};
      default: {alu_result, alu_carry} = {1'b0, alu_a};
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    total_cnt++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  task automatic ref_alu(input int op, input int a, input int b,
                         output int r, output int z, output int c);
    int s;
    c = 0;
    case (op)
      0: begin s = a + b; c = (s > 255); r = s % 256; end
      1: begin s = a - b; c = (a < b); r = (s < 0) ? s + 256 : s; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a < b) ? 1 : 0;
      6: begin s = a * 2; c = (s > 255); r = s % 256; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    z = (r == 0);
  endtask

  task automatic push_expect(input int op, input int rd, input int a, input int b);
    exp_t e;
    int   r, z, c;
    ref_alu(op, a, b, r, z, c);
    e.data = r;
    e.rd   = rd;
`ifdef ALU_SEQ_FLAGS_EN
    e.z = z;
    e.c = c;
`else
    e.z = 0;
    e.c = 0;
`endif
    sb_q.push_back(e);
    mreg[rd] = r;
    issued++;
  endtask

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    while (!ld_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin timeout_fail("ld_accept"); ld_valid = 1'b0; return; end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    mreg[a] = d;
    $display("LOAD r%0d = %02h", a, d);
  endtask

  task automatic do_instr(input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input int hold);
    int n = 0;
    int a, b, r, z, c;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    #1;
    while (!instr_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin timeout_fail("instr_accept"); instr_valid = 1'b0; return; end
    a = mreg[rs1];
    b = mreg[rs2];
    ref_alu(op, a, b, r, z, c);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (hold > 0) resp_ready = 1'b0;
    push_expect(op, rd, a, b);
    $display("INSTR op=%0d rd=%0d rs1=%0d rs2=%0d a=%02h b=%02h -> %02h hold=%0d",
             op, rd, rs1, rs2, a, b, r, hold);
    @(negedge clk);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_sel", alu_sel, op);
    check("exec_resp_valid", resp_valid, 0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_resp_valid", resp_valid, 1);
        check("hold_resp_data", resp_data, r);
        check("hold_resp_rd", resp_rd, rd);
        check("hold_instr_ready", instr_ready, 0);
        check("hold_ld_ready", ld_ready, 0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
  endtask

  // Monitor: every response handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_resp: got data %02h rd %0d, expected none", resp_data, resp_rd);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_rd", resp_rd, e.rd);
        check("flag_zero", flag_zero, e.z);
        check("flag_carry", flag_carry, e.c);
        resp_cnt++;
        $display("RESP rd=%0d data=%02h z=%0d c=%0d", resp_rd, resp_data, flag_zero, flag_carry);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_ld_ready"}, ld_ready, 1);
    check({tag, "_instr_ready"}, instr_ready, 1);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_flag_zero"}, flag_zero, 0);
    check({tag, "_flag_carry"}, flag_carry, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    #2;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    do_load(2'd0, 8'h05); do_load(2'd1, 8'h03);
    do_instr(3'd0, 2'd2, 2'd0, 2'd1, 0);
    do_instr(3'd3, 2'd3, 2'd2, 2'd2, 0);   // reads back r2 through alu_a/alu_b
    do_load(2'd0, 8'hFF); do_load(2'd1, 8'h01);
    do_instr(3'd0, 2'd2, 2'd0, 2'd1, 0);
    do_load(2'd0, 8'h03); do_load(2'd1, 8'h05);
    do_instr(3'd1, 2'd2, 2'd0, 2'd1, 0);
    do_instr(3'd5, 2'd3, 2'd0, 2'd1, 0);
    do_instr(3'd4, 2'd0, 2'd0, 2'd1, 5);   // rd == rs1, with 5-cycle backpressure

    // Preload and instruction offered together: preload wins
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 8'h10;
    instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 2'd3; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
    #1;
    n = 0;
    while (!ld_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("prio_instr_ready", instr_ready, 0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    mreg[0] = 32'h10;
    #1;
    check("prio_instr_ready_after", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    push_expect(0, 3, mreg[0], mreg[1]);
    $display("INSTR (after preload) op=0 rd=3 rs1=0 rs2=1");
    @(negedge clk);
    check("prio_alu_a", alu_a, 32'h10);

    // Reset during EXEC discards the instruction and clears all state
    do_load(2'd1, 8'h22);
    n = 0;
    while (resp_valid && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
    #1;
    n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    $display("RESET asserted during EXEC");
    repeat (3) begin
      @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
    end
    check_reset_state("rst");
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_resp_valid", resp_valid, 0);
    do_instr(3'd3, 2'd3, 2'd1, 2'd2, 0);
    do_instr(3'd0, 2'd0, 2'd3, 2'd0, 0);

    // Randomised traffic
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else
        do_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    n = 0;
    while (sb_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    check("sb_drained", sb_q.size(), 0);
    check("resp_count", resp_cnt, issued);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
